// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions for the fetch-stage PC sequencer: address width and
// the legacy state encoding.
package pc_sequencer_pkg;

    localparam int unsigned ADDR_W = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [1:0]        state_t;

    localparam state_t ST_HALTED = 2'd0;
    localparam state_t ST_RUN    = 2'd1;
    localparam state_t ST_PEND   = 2'd2;
    localparam state_t ST_DRAIN  = 2'd3;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the pipeline and the PC sequencer; the core
// side drives requests (master), the sequencer answers (slave).
interface pc_sequencer_if;
    import pc_sequencer_pkg::*;

    logic        start;
    addr_t       start_addr;
    logic        br_taken;
    addr_t       br_target;
    logic        halt_req;
    logic        mem_busy;
    logic        hazard_stall;
    logic        pc_ce;
    logic        pc_branch;
    addr_t       pc_target;
    logic        hold_ifid;
    logic        flush_ifid;
    logic        flush_idex;
    logic        halted;
    logic [15:0] stall_count;

    modport master (
        output start, start_addr, br_taken, br_target, halt_req, mem_busy, hazard_stall,
        input  pc_ce, pc_branch, pc_target, hold_ifid, flush_ifid, flush_idex, halted,
               stall_count
    );

    modport slave (
        input  start, start_addr, br_taken, br_target, halt_req, mem_busy, hazard_stall,
        output pc_ce, pc_branch, pc_target, hold_ifid, flush_ifid, flush_idex, halted,
               stall_count
    );

endinterface

// File: rtl/pc_sequencer_sat_counter16.sv
// 16-bit up-counter that sticks at all-ones; cleared only by reset.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != '1)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: arbitrates redirect, memory wait, hazard stall,
// halt and restart, and drives the matching IF/ID and ID/EX flush/hold controls.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input logic              clk,
    input logic              rst,
    pc_sequencer_if.slave    bus
);

    state_t     state_q, state_d;
    addr_t      pend_q,  pend_d;
    addr_t      tgt_q,   tgt_d;
    logic [3:0] drain_q, drain_d;

    logic ce, br, hold, fl_ifid, fl_idex;

    // pc_target follows the load value in a branch cycle and otherwise
    // repeats the last loaded target, so tgt_d doubles as the output.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        tgt_d   = tgt_q;
        drain_d = drain_q;
        ce      = 1'b0;
        br      = 1'b0;
        hold    = 1'b0;
        fl_ifid = 1'b0;
        fl_idex = 1'b0;
        case (state_q)
            ST_HALTED: begin
                hold = 1'b1;
                if (bus.start && !rst) begin
                    br      = 1'b1;
                    tgt_d   = bus.start_addr;
                    fl_ifid = 1'b1;
                    fl_idex = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.halt_req) begin
                    fl_ifid = 1'b1;
                    fl_idex = 1'b1;
                    drain_d = 4'(DRAIN_CYCLES);
                    state_d = ST_DRAIN;
                end else if (bus.br_taken && !bus.mem_busy) begin
                    br      = 1'b1;
                    tgt_d   = bus.br_target;
                    fl_ifid = 1'b1;
                    fl_idex = 1'b1;
                end else if (bus.br_taken) begin
                    pend_d  = bus.br_target;
                    hold    = 1'b1;
                    fl_idex = 1'b1;
                    state_d = ST_PEND;
                end else if (bus.mem_busy) begin
                    hold = 1'b1;
                end else if (bus.hazard_stall) begin
                    hold    = 1'b1;
                    fl_idex = 1'b1;
                end else begin
                    ce = 1'b1;
                end
            end
            ST_PEND: begin
                if (bus.halt_req) begin
                    fl_ifid = 1'b1;
                    fl_idex = 1'b1;
                    pend_d  = '0;
                    drain_d = 4'(DRAIN_CYCLES);
                    state_d = ST_DRAIN;
                end else if (!bus.mem_busy) begin
                    br      = 1'b1;
                    tgt_d   = pend_q;
                    fl_ifid = 1'b1;
                    fl_idex = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    hold = 1'b1;
                end
            end
            ST_DRAIN: begin
                fl_ifid = 1'b1;
                drain_d = drain_q - 4'd1;
                if (drain_q <= 4'd1) begin
                    state_d = ST_HALTED;
                end
            end
            default: state_d = ST_HALTED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HALTED;
            pend_q  <= '0;
            tgt_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
            drain_q <= drain_d;
        end
    end

    logic stall_en;
    assign stall_en = ((state_q == ST_RUN) || (state_q == ST_PEND)) && !ce && !br;

    sat_counter16 u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .en_i    (stall_en),
        .count_o (bus.stall_count)
    );

    assign bus.pc_ce      = ce;
    assign bus.pc_branch  = br;
    assign bus.pc_target  = tgt_d;
    assign bus.hold_ifid  = hold;
    assign bus.flush_ifid = fl_ifid;
    assign bus.flush_idex = fl_idex;
    assign bus.halted     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a per-cycle vector table walking restart,
// redirect, pending redirect, stalls, halt/drain, plus a reset-in-PEND sequence.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sequencer_if bus ();

    pc_sequencer #(.DRAIN_CYCLES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        st;
        logic [15:0] sa;
        logic        bt;
        logic [15:0] btg;
        logic        hr;
        logic        mb;
        logic        hz;
        logic [21:0] exp_o;   // {ce, br, target, hold, flush_ifid, flush_idex, halted}
        logic [15:0] exp_sc;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    function automatic vec_t mk(input logic st, input logic [15:0] sa, input logic bt,
                                input logic [15:0] btg, input logic hr, input logic mb,
                                input logic hz, input logic ce, input logic br,
                                input logic [15:0] tgt, input logic hold, input logic fi,
                                input logic fx, input logic hlt, input logic [15:0] sc);
        vec_t v;
        v.st = st; v.sa = sa; v.bt = bt; v.btg = btg; v.hr = hr; v.mb = mb; v.hz = hz;
        v.exp_o  = {ce, br, tgt, hold, fi, fx, hlt};
        v.exp_sc = sc;
        return v;
    endfunction

    function automatic logic [21:0] outs();
        return {bus.pc_ce, bus.pc_branch, bus.pc_target, bus.hold_ifid,
                bus.flush_ifid, bus.flush_idex, bus.halted};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.start        = v.st;
        bus.start_addr   = v.sa;
        bus.br_taken     = v.bt;
        bus.br_target    = v.btg;
        bus.halt_req     = v.hr;
        bus.mem_busy     = v.mb;
        bus.hazard_stall = v.hz;
    endtask

    initial begin
        //             st  sa       bt  btg      hr mb hz   ce br tgt      hd fi fx hl  sc
        vecs[0]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0,   0, 0, 16'h0000, 1, 0, 0, 1, 16'd0);
        vecs[1]  = mk(1, 16'h0040, 0, 16'h0000, 0, 0, 0,   0, 1, 16'h0040, 1, 1, 1, 1, 16'd0);
        vecs[2]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0,   1, 0, 16'h0040, 0, 0, 0, 0, 16'd0);
        vecs[3]  = mk(0, 16'h0000, 1, 16'h1234, 0, 0, 0,   0, 1, 16'h1234, 0, 1, 1, 0, 16'd0);
        vecs[4]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0,   1, 0, 16'h1234, 0, 0, 0, 0, 16'd0);
        vecs[5]  = mk(0, 16'h0000, 1, 16'h00AA, 0, 1, 0,   0, 0, 16'h1234, 1, 0, 1, 0, 16'd0);
        vecs[6]  = mk(0, 16'h0000, 0, 16'h0000, 0, 1, 0,   0, 0, 16'h1234, 1, 0, 0, 0, 16'd1);
        vecs[7]  = mk(0, 16'h0000, 1, 16'hFFFF, 0, 1, 1,   0, 0, 16'h1234, 1, 0, 0, 0, 16'd2);
        vecs[8]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0,   0, 1, 16'h00AA, 0, 1, 1, 0, 16'd3);
        vecs[9]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0,   1, 0, 16'h00AA, 0, 0, 0, 0, 16'd3);
        vecs[10] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 1,   0, 0, 16'h00AA, 1, 0, 1, 0, 16'd3);
        vecs[11] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 1,   0, 0, 16'h00AA, 1, 0, 1, 0, 16'd4);
        vecs[12] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0,   1, 0, 16'h00AA, 0, 0, 0, 0, 16'd5);
        vecs[13] = mk(0, 16'h0000, 0, 16'h0000, 0, 1, 0,   0, 0, 16'h00AA, 1, 0, 0, 0, 16'd5);
        vecs[14] = mk(0, 16'h0000, 0, 16'h0000, 0, 1, 1,   0, 0, 16'h00AA, 1, 0, 0, 0, 16'd6);
        vecs[15] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0,   1, 0, 16'h00AA, 0, 0, 0, 0, 16'd7);
        vecs[16] = mk(0, 16'h0000, 1, 16'h5555, 1, 0, 0,   0, 0, 16'h00AA, 0, 1, 1, 0, 16'd7);
        vecs[17] = mk(1, 16'h9999, 0, 16'h0000, 0, 0, 0,   0, 0, 16'h00AA, 0, 1, 0, 0, 16'd8);
        vecs[18] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0,   0, 0, 16'h00AA, 0, 1, 0, 0, 16'd8);
        vecs[19] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0,   0, 0, 16'h00AA, 0, 1, 0, 0, 16'd8);
        vecs[20] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0,   0, 0, 16'h00AA, 1, 0, 0, 1, 16'd8);
        vecs[21] = mk(1, 16'h0100, 0, 16'h0000, 0, 0, 0,   0, 1, 16'h0100, 1, 1, 1, 1, 16'd8);
        vecs[22] = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0,   1, 0, 16'h0100, 0, 0, 0, 0, 16'd8);

        rst = 1'b1;
        drive(vecs[0]);
        #12;
        check("reset_outs", 32'(outs()), 32'({1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}));
        check("reset_stall", 32'(bus.stall_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp_o));
            check($sformatf("vec%0d_stall", i), 32'(bus.stall_count), 32'(vecs[i].exp_sc));
        end

        // Redirect parked in PEND, then reset lands while it would be released.
        @(negedge clk);
        bus.br_taken = 1'b1; bus.br_target = 16'h0BAD; bus.mem_busy = 1'b1;
        #2;
        check("pend_entry_hold", 32'({bus.hold_ifid, bus.pc_branch}), 32'(2'b10));
        @(negedge clk);
        bus.br_taken = 1'b0; bus.br_target = 16'h0000; bus.mem_busy = 1'b0;
        #1;
        check("pend_release", 32'({bus.pc_branch, bus.pc_target}), 32'({1'b1, 16'h0BAD}));
        rst = 1'b1;
        #1;
        check("async_reset_outs", 32'(outs()), 32'({1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}));
        check("async_reset_stall", 32'(bus.stall_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b1; bus.start_addr = 16'h0200;
        #2;
        check("restart_after_reset", 32'(outs()), 32'({1'b0, 1'b1, 16'h0200, 1'b1, 1'b1, 1'b1, 1'b1}));
        @(negedge clk);
        bus.start = 1'b0; bus.start_addr = 16'h0000;
        #2;
        check("run_after_restart", 32'(outs()), 32'({1'b1, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0}));
        check("stall_after_restart", 32'(bus.stall_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
